// File: rtl/vec_issue_ctrl.sv
// Single-issue sequencer between the dispatcher and the vector ALU / register file.
// Each instruction walks READ -> WAIT -> EXEC -> WRITE; ZERO skips the reads, illegal ops take ERR.
module vec_issue_ctrl #(
    parameter int WIDTH  = 128,
    parameter int NREG   = 16,
    parameter int REG_AW = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [3:0]               instr_op,
    input  logic [REG_AW-1:0]        instr_rd,
    input  logic [REG_AW-1:0]        instr_rs1,
    input  logic [REG_AW-1:0]        instr_rs2,
    input  logic [31:0]              instr_imm,
    output logic                     rf_rd_en,
    output logic [REG_AW-1:0]        rf_rd_addr1,
    output logic [REG_AW-1:0]        rf_rd_addr2,
    input  logic [WIDTH-1:0][31:0]   rf_rd_data1,
    input  logic [WIDTH-1:0][31:0]   rf_rd_data2,
    output logic [3:0]               vu_op,
    output logic [31:0]              vu_inK,
    output logic [WIDTH-1:0][31:0]   vu_in1,
    output logic [WIDTH-1:0][31:0]   vu_in2,
    input  logic [WIDTH-1:0][31:0]   vu_out,
    output logic                     rf_wr_en,
    output logic [REG_AW-1:0]        rf_wr_addr,
    output logic [WIDTH-1:0][31:0]   rf_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_op,
    output logic [31:0]              retired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EXEC,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_LAST = 4'd8;

    if (NREG > (1 << REG_AW)) begin : g_bad_nreg
        $error("vec_issue_ctrl: NREG does not fit in REG_AW address bits");
    end

    state_t                   state_q, state_d;
    logic [3:0]               op_q, op_d;
    logic [REG_AW-1:0]        rd_q, rd_d;
    logic [REG_AW-1:0]        rs1_q, rs1_d;
    logic [REG_AW-1:0]        rs2_q, rs2_d;
    logic [31:0]              imm_q, imm_d;
    logic [WIDTH-1:0][31:0]   opnd1_q, opnd1_d;
    logic [WIDTH-1:0][31:0]   opnd2_q, opnd2_d;
    logic [WIDTH-1:0][31:0]   result_q, result_d;
    logic                     instr_ready_q, instr_ready_d;
    logic                     busy_q, busy_d;
    logic                     rf_rd_en_q, rf_rd_en_d;
    logic [REG_AW-1:0]        rf_rd_addr1_q, rf_rd_addr1_d;
    logic [REG_AW-1:0]        rf_rd_addr2_q, rf_rd_addr2_d;
    logic [3:0]               vu_op_q, vu_op_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic [REG_AW-1:0]        rf_wr_addr_q, rf_wr_addr_d;
    logic                     done_q, done_d;
    logic                     err_op_q, err_op_d;
    logic [31:0]              retired_count_q, retired_count_d;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        rd_d            = rd_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        imm_d           = imm_q;
        opnd1_d         = opnd1_q;
        opnd2_d         = opnd2_q;
        result_d        = result_q;
        retired_count_d = retired_count_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    op_d  = instr_op;
                    rd_d  = instr_rd;
                    rs1_d = instr_rs1;
                    rs2_d = instr_rs2;
                    imm_d = instr_imm;
                    if (instr_op > OP_LAST) begin
                        state_d = S_ERR;
                    end else if (instr_op == OP_ZERO) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                // Register-file data is valid in the cycle after the read strobe.
                opnd1_d = rf_rd_data1;
                opnd2_d = rf_rd_data2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = vu_out;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (retired_count_q != 32'hFFFF_FFFF) begin
                    retired_count_d = retired_count_q + 32'd1;
                end
                state_d = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        rf_rd_en_d    = (state_d == S_READ);
        rf_rd_addr1_d = (state_d == S_READ) ? rs1_d : '0;
        rf_rd_addr2_d = (state_d == S_READ) ? rs2_d : '0;
        vu_op_d       = (state_d == S_EXEC) ? op_d : OP_ZERO;
        rf_wr_en_d    = (state_d == S_WRITE);
        rf_wr_addr_d  = (state_d == S_WRITE) ? rd_d : '0;
        done_d        = (state_d == S_WRITE);
        err_op_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            op_q            <= OP_ZERO;
            rd_q            <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            imm_q           <= '0;
            opnd1_q         <= '0;
            opnd2_q         <= '0;
            result_q        <= '0;
            instr_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            rf_rd_en_q      <= 1'b0;
            rf_rd_addr1_q   <= '0;
            rf_rd_addr2_q   <= '0;
            vu_op_q         <= OP_ZERO;
            rf_wr_en_q      <= 1'b0;
            rf_wr_addr_q    <= '0;
            done_q          <= 1'b0;
            err_op_q        <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            rd_q            <= rd_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            imm_q           <= imm_d;
            opnd1_q         <= opnd1_d;
            opnd2_q         <= opnd2_d;
            result_q        <= result_d;
            instr_ready_q   <= instr_ready_d;
            busy_q          <= busy_d;
            rf_rd_en_q      <= rf_rd_en_d;
            rf_rd_addr1_q   <= rf_rd_addr1_d;
            rf_rd_addr2_q   <= rf_rd_addr2_d;
            vu_op_q         <= vu_op_d;
            rf_wr_en_q      <= rf_wr_en_d;
            rf_wr_addr_q    <= rf_wr_addr_d;
            done_q          <= done_d;
            err_op_q        <= err_op_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign instr_ready   = instr_ready_q;
    assign busy          = busy_q;
    assign rf_rd_en      = rf_rd_en_q;
    assign rf_rd_addr1   = rf_rd_addr1_q;
    assign rf_rd_addr2   = rf_rd_addr2_q;
    assign vu_op         = vu_op_q;
    assign vu_inK        = imm_q;
    assign vu_in1        = opnd1_q;
    assign vu_in2        = opnd2_q;
    assign rf_wr_en      = rf_wr_en_q;
    assign rf_wr_addr    = rf_wr_addr_q;
    assign rf_wr_data    = result_q;
    assign done          = done_q;
    assign err_op        = err_op_q;
    assign retired_count = retired_count_q;

endmodule
